// File: rtl/beq_truth_table_checker_if.sv
// beq_truth_table_checker_if: run control, results and probe signals of the truth table checker
interface beq_truth_table_checker_if;
  logic        start;
  logic [15:0] exp_table;
  logic        z_in;
  logic        a_out, c_out, b_out, d_out;
  logic        busy, done, pass;
  logic [15:0] table_out;
  logic [4:0]  err_count;
  logic [3:0]  first_err_idx;
  modport master (
    output start, exp_table, z_in,
    input  a_out, c_out, b_out, d_out, busy, done, pass, table_out, err_count, first_err_idx
  );
  modport slave (
    input  start, exp_table, z_in,
    output a_out, c_out, b_out, d_out, busy, done, pass, table_out, err_count, first_err_idx
  );
endinterface

// File: rtl/beq_truth_table_checker.sv
// beq_truth_table_checker: drives all 16 {A,C,B,D} vectors, samples Z and checks the truth table
module beq_truth_table_checker #(
   parameter int SETTLE_CYCLES = 2
) (
   input logic                     clk,
   input logic                     rst_n,
   beq_truth_table_checker_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
   state_t      state, state_nx;
   logic [3:0]  idx, cnt, first_q;
   logic [15:0] exp_q, table_q;
   logic [4:0]  err_q;
   logic        pass_q, done_q, busy_c, miss;
   assign miss = bus.z_in != exp_q[idx];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      busy_c   = 1'b0;
      case (state)
         IDLE:    state_nx = bus.start ? SETTLE : IDLE;
         SETTLE:  begin busy_c = 1'b1; state_nx = cnt == 4'd0 ? SAMPLE : SETTLE; end
         SAMPLE:  begin busy_c = 1'b1; state_nx = idx == 4'd15 ? DONE : SETTLE; end
         default: state_nx = IDLE;
      endcase
   end
   // idx doubles as the registered vector drive; it is cleared when leaving DONE
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         idx     <= '0;
         cnt     <= '0;
         exp_q   <= '0;
         table_q <= '0;
         err_q   <= '0;
         first_q <= '0;
         pass_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= state == DONE;
         case (state)
            IDLE: if (bus.start) begin
               exp_q   <= bus.exp_table;
               table_q <= '0;
               err_q   <= '0;
               first_q <= '0;
               pass_q  <= 1'b0;
               idx     <= '0;
               cnt     <= 4'(SETTLE_CYCLES - 1);
            end
            SETTLE: if (cnt != 4'd0) cnt <= cnt - 4'd1;
            SAMPLE: begin
               table_q[idx] <= bus.z_in;
               if (miss) err_q <= err_q + 5'd1;
               if (miss && err_q == 5'd0) first_q <= idx;
               if (idx != 4'd15) begin
                  idx <= idx + 4'd1;
                  cnt <= 4'(SETTLE_CYCLES - 1);
               end
            end
            default: begin
               pass_q <= err_q == 5'd0;
               idx    <= '0;
            end
         endcase
      end
   assign bus.a_out         = idx[3];
   assign bus.c_out         = idx[2];
   assign bus.b_out         = idx[1];
   assign bus.d_out         = idx[0];
   assign bus.busy          = busy_c;
   assign bus.done          = done_q;
   assign bus.pass          = pass_q;
   assign bus.table_out     = table_q;
   assign bus.err_count     = err_q;
   assign bus.first_err_idx = first_q;
endmodule

// File: tb/tb_beq_truth_table_checker.sv
// tb_beq_truth_table_checker: scoreboard bench, a random Boolean function is the block under test
module tb_beq_truth_table_checker;
   typedef struct {
      logic [15:0] tbl;
      int          err;
      int          first;
      bit          pass;
   } exp_t;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] fn = '0;
   int          checks = 0;
   int          errors = 0;
   exp_t        q[$];
   beq_truth_table_checker_if bus();
   beq_truth_table_checker #(.SETTLE_CYCLES(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   // the function under test is simply a truth table indexed by the driven vector
   assign bus.z_in = fn[{bus.a_out, bus.c_out, bus.b_out, bus.d_out}];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask
   function automatic exp_t model(input logic [15:0] f, input logic [15:0] e);
      exp_t r;
      r.tbl   = f;
      r.err   = 0;
      r.first = -1;
      for (int i = 0; i < 16; i++)
         if (f[i] != e[i]) begin
            if (r.first < 0) r.first = i;
            r.err++;
         end
      r.pass = r.err == 0;
      return r;
   endfunction
   always @(negedge clk)
      if (rst_n && bus.done) begin
         if (q.size() == 0) chk("unexpected_done", 1, 0);
         else begin
            exp_t e;
            e = q.pop_front();
            chk("table_out", 32'(bus.table_out), 32'(e.tbl));
            chk("err_count", 32'(bus.err_count), 32'(e.err));
            chk("pass", 32'(bus.pass), 32'(e.pass));
            if (e.err != 0) chk("first_err_idx", 32'(bus.first_err_idx), 32'(e.first));
         end
      end
   task automatic all_zero(input string name);
      chk(name, {bus.a_out, bus.c_out, bus.b_out, bus.d_out, bus.busy, bus.done, bus.pass,
                 bus.table_out, bus.err_count, bus.first_err_idx}, 0);
   endtask
   // one full run; k counts edges after the accept edge, outputs sampled mid-cycle
   task automatic run(input logic [15:0] f, input logic [15:0] e, input bit poke);
      bit ok = 1'b1;
      int bad_k = -1;
      fn = f;
      bus.exp_table = e;
      bus.start = 1'b1;
      @(posedge clk);
      q.push_back(model(f, e));
      #1 bus.start = 1'b0;
      for (int k = 0; k <= 50; k++) begin
         bit          eb, ed;
         logic [3:0]  ev;
         if (k > 0) @(posedge clk);
         @(negedge clk);
         eb = k <= 47;
         ed = k == 49;
         ev = k <= 47 ? 4'(k / 3) : (k == 48 ? 4'd15 : 4'd0);
         if (bus.busy !== eb || bus.done !== ed || {bus.a_out, bus.c_out, bus.b_out, bus.d_out} !== ev) begin
            if (ok) bad_k = k;
            ok = 1'b0;
         end
         if (poke && k == 16) begin
            bus.start = 1'b1;
            bus.exp_table = 16'hFFFF;
         end
         if (poke && k == 17) bus.start = 1'b0;
      end
      chk("vector_sequence", {ok, 31'(bad_k + 1)}, {1'b1, 31'd0});
   endtask
   initial begin
      bus.start = 1'b0;
      bus.exp_table = '0;
      #12 all_zero("reset_outputs");
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(negedge clk);
      run(16'hAAAA, 16'hAAAA, 1'b0);
      run(16'h0000, 16'hAAAA, 1'b0);
      run(16'hAAAA, 16'hAAAA, 1'b1);
      run(16'hAAAA, 16'h2AAA, 1'b0);
      run(16'h5555, 16'h5554, 1'b0);
      // abort mid-vector 7 with an asynchronous reset
      fn = 16'hAAAA;
      bus.exp_table = 16'hAAAA;
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (22) @(posedge clk);
      @(negedge clk);
      chk("mid_run_vector", 32'({bus.a_out, bus.c_out, bus.b_out, bus.d_out}), 32'd7);
      #2 rst_n = 1'b0;
      #1 all_zero("async_abort");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (60) @(negedge clk);
      all_zero("idle_after_abort");
      run(16'hC3A5, 16'h0000, 1'b0);
      for (int i = 0; i < 6; i++) begin
         logic [15:0] f, e;
         f = 16'($urandom);
         e = $urandom_range(0, 1) ? f : 16'($urandom);
         run(f, e, 1'b0);
      end
      repeat (4) @(negedge clk);
      chk("scoreboard_drained", 32'(q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
